// File: rtl/jtpang_eeprom.sv
// jtpang_eeprom: 93C46-style serial EEPROM (64 x 16) driven by bit-banged
// CPU latches, with a byte-wide NVRAM port for dump/restore.
// Optional macro JTPANG_EEPROM_BUSY_EN adds a post-commit busy period on sdo.
// The array is stored inverted so a zero-initialised RAM reads back as the
// erased value 16'hFFFF.
module jtpang_eeprom #(
    parameter int BUSY_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       sclk,
    input  logic       sdi,
    output logic       sdo,
    input  logic [6:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic       prog_we,
    output logic [7:0] prog_din
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        READ    = 3'd2,
        WDATA   = 3'd3,
        WAIT_CS = 3'd4,
        CLR     = 3'd5
    } state_t;

    state_t      state_r;
    logic        sclk_r, sclk_prev_r, sdi_r;
    logic [3:0]  cnt_r;
    logic [6:0]  cmd_r;
    logic [5:0]  addr_r;
    logic [15:0] data_r;
    logic        wen_r, pend_r, all_r;
    logic [15:0] mem_inv_r [0:63];

    logic        rise_s;
    logic [7:0]  cmd_s;
    logic        cpu_we_s;
    logic        prog_ok_s;
    logic [15:0] prog_word_s;
    logic        busy_s;

    assign rise_s      = sclk_r & ~sclk_prev_r;
    assign cmd_s       = {cmd_r, sdi_r};
    assign prog_word_s = ~mem_inv_r[prog_addr[6:1]];

`ifdef JTPANG_EEPROM_BUSY_EN
    localparam int BUSY_W = $clog2(BUSY_CYC + 1);
    logic [BUSY_W-1:0] busy_r;
    logic              commit_s;

    assign commit_s = (state_r == WAIT_CS) && !cs && pend_r && wen_r;
    assign busy_s   = (busy_r != '0);

    // Busy countdown started by every write/erase that actually commits
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= '0;
        end else if (commit_s) begin
            busy_r <= BUSY_W'(BUSY_CYC);
        end else if (busy_s) begin
            busy_r <= busy_r - {{(BUSY_W-1){1'b0}}, 1'b1};
        end else begin
            busy_r <= busy_r;
        end
    end
`else
    assign busy_s = 1'b0;
`endif

    // Decide whether the CPU side writes the array this cycle (commit or sweep)
    always_comb begin
        cpu_we_s = 1'b0;
        if (rst) begin
            cpu_we_s = 1'b0;
        end else if (state_r == WAIT_CS && !cs && pend_r && wen_r && !all_r) begin
            cpu_we_s = 1'b1;
        end else if (state_r == CLR) begin
            cpu_we_s = 1'b1;
        end else begin
            cpu_we_s = 1'b0;
        end
    end

    // NVRAM byte writes lose to CPU commits on the same word and to sweeps
    always_comb begin
        prog_ok_s = 1'b0;
        if (!prog_we || state_r == CLR) begin
            prog_ok_s = 1'b0;
        end else if (cpu_we_s && addr_r == prog_addr[6:1]) begin
            prog_ok_s = 1'b0;
        end else begin
            prog_ok_s = 1'b1;
        end
    end

    // Array storage: no reset so contents survive rst
    always_ff @(posedge clk) begin
        if (prog_ok_s) begin
            if (prog_addr[0]) begin
                mem_inv_r[prog_addr[6:1]][15:8] <= ~prog_data;
            end else begin
                mem_inv_r[prog_addr[6:1]][7:0] <= ~prog_data;
            end
        end
        if (cpu_we_s) begin
            mem_inv_r[addr_r] <= ~data_r;
        end
    end

    // Registered NVRAM dump byte
    always_ff @(posedge clk) begin
        if (rst) begin
            prog_din <= 8'h00;
        end else begin
            prog_din <= prog_addr[0] ? prog_word_s[15:8] : prog_word_s[7:0];
        end
    end

    // Input synchronisation and sclk edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_r      <= 1'b0;
            sclk_prev_r <= 1'b0;
            sdi_r       <= 1'b0;
        end else begin
            sclk_r      <= sclk;
            sclk_prev_r <= sclk_r;
            sdi_r       <= sdi;
        end
    end

    // Serial protocol FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            sdo     <= 1'b1;
            wen_r   <= 1'b0;
            cnt_r   <= 4'd0;
            cmd_r   <= 7'd0;
            addr_r  <= 6'd0;
            data_r  <= 16'd0;
            pend_r  <= 1'b0;
            all_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    sdo <= ~(cs & busy_s);
                    if (cs && rise_s && sdi_r && !busy_s) begin
                        state_r <= CMD;
                        cnt_r   <= 4'd0;
                        pend_r  <= 1'b0;
                        all_r   <= 1'b0;
                    end
                end
                CMD: begin
                    if (!cs) begin
                        state_r <= IDLE;
                        sdo     <= 1'b1;
                    end else if (rise_s) begin
                        cmd_r <= cmd_s[6:0];
                        cnt_r <= cnt_r + 4'd1;
                        if (cnt_r == 4'd7) begin
                            addr_r <= cmd_s[5:0];
                            cnt_r  <= 4'd0;
                            case (cmd_s[7:6])
                                2'b10: begin
                                    data_r  <= ~mem_inv_r[cmd_s[5:0]];
                                    sdo     <= 1'b0;
                                    state_r <= READ;
                                end
                                2'b01: state_r <= WDATA;
                                2'b11: begin
                                    data_r  <= 16'hFFFF;
                                    pend_r  <= 1'b1;
                                    state_r <= WAIT_CS;
                                end
                                default: begin
                                    state_r <= WAIT_CS;
                                    case (cmd_s[5:4])
                                        2'b11: wen_r <= 1'b1;
                                        2'b00: wen_r <= 1'b0;
                                        2'b10: begin
                                            data_r <= 16'hFFFF;
                                            pend_r <= 1'b1;
                                            all_r  <= 1'b1;
                                        end
                                        default: begin
                                            all_r   <= 1'b1;
                                            state_r <= WDATA;
                                        end
                                    endcase
                                end
                            endcase
                        end
                    end
                end
                READ: begin
                    if (!cs) begin
                        state_r <= IDLE;
                        sdo     <= 1'b1;
                    end else if (rise_s) begin
                        sdo    <= data_r[15];
                        data_r <= {data_r[14:0], 1'b1};
                    end
                end
                WDATA: begin
                    if (!cs) begin
                        state_r <= IDLE;
                        sdo     <= 1'b1;
                    end else if (rise_s) begin
                        data_r <= {data_r[14:0], sdi_r};
                        cnt_r  <= cnt_r + 4'd1;
                        if (cnt_r == 4'd15) begin
                            pend_r  <= 1'b1;
                            state_r <= WAIT_CS;
                        end
                    end
                end
                WAIT_CS: begin
                    sdo <= 1'b1;
                    if (!cs) begin
                        pend_r <= 1'b0;
                        if (pend_r && wen_r && all_r) begin
                            addr_r  <= 6'd0;
                            state_r <= CLR;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                CLR: begin
                    sdo    <= ~(cs & busy_s);
                    addr_r <= addr_r + 6'd1;
                    if (addr_r == 6'd63) begin
                        all_r   <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    sdo     <= 1'b1;
                end
            endcase
        end
    end

endmodule
